// File: rtl/fifo_pkg.sv
// Shared definitions for the ip_fifo read-side stream adapter.
// Holds default WIDTH/DEPTH and the helpers that size the occupancy counter
// and the circular-buffer pointers.
package fifo_pkg;

  localparam int unsigned FIFO_WIDTH = 8;
  localparam int unsigned FIFO_DEPTH = 3;

  // Occupancy counts 0..depth inclusive.
  function automatic int unsigned occ_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // Pointer addresses 0..depth-1; never narrower than one bit.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/fifo_rd_stream_if.sv
// Bus bundle for fifo_rd_stream.
//   ip_fifo side : empty (to adapter), rd_en (from adapter), dout (to adapter)
//   stream side  : m_valid/m_data (from adapter), m_ready (to adapter)
// Modports: master = the adapter, slave = the ip_fifo plus stream consumer.
interface fifo_rd_stream_if
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH = FIFO_WIDTH
);

  logic             empty;
  logic             rd_en;
  logic [WIDTH-1:0] dout;
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;

  modport master (
    input  empty,
    input  dout,
    input  m_ready,
    output rd_en,
    output m_valid,
    output m_data
  );

  modport slave (
    output empty,
    output dout,
    output m_ready,
    input  rd_en,
    input  m_valid,
    input  m_data
  );

endinterface

// File: rtl/fifo_rd_buf.sv
// Circular capture buffer for fifo_rd_stream.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   wr_en        capture wr_data into the slot at wptr
//   wr_data      word to capture
//   rd_en        retire the word at rptr (caller guarantees occ != 0)
//   rd_data_c    word at rptr, combinational from state
//   occ          number of held words, 0..DEPTH
// The data array is not reset; only pointers and occupancy are.
module fifo_rd_buf
  import fifo_pkg::*;
#(
  parameter  int unsigned WIDTH = FIFO_WIDTH,
  parameter  int unsigned DEPTH = FIFO_DEPTH,
  localparam int unsigned OCC_W = occ_w(DEPTH),
  localparam int unsigned PTR_W = ptr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data_c,
  output logic [OCC_W-1:0] occ
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;

  // Advance a pointer, wrapping DEPTH-1 back to 0.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      occ  <= '0;
    end else begin
      if (wr_en) wptr <= ptr_inc(wptr);
      if (rd_en) rptr <= ptr_inc(rptr);
      occ <= occ + OCC_W'(wr_en) - OCC_W'(rd_en);
    end
  end

  // Data storage, no reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr] <= wr_data;
  end

  assign rd_data_c = mem[rptr];

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side adapter for ip_fifo: issues rd_en, captures dout one cycle later
// into a small circular buffer and presents it as a first-word-fall-through
// valid/ready stream.
// Ports:
//   clk        read-domain clock (ip_fifo rd_clk)
//   rst        asynchronous active-high reset
//   word_cnt   32-bit pop counter, present only with FIFO_RD_STREAM_CNT_EN
//   bus        fifo_rd_stream_if.master: empty/rd_en/dout, m_valid/m_ready/m_data
// Optional feature macro: FIFO_RD_STREAM_CNT_EN.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter  int unsigned WIDTH = FIFO_WIDTH,
  parameter  int unsigned DEPTH = FIFO_DEPTH,
  localparam int unsigned OCC_W = occ_w(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
`ifdef FIFO_RD_STREAM_CNT_EN
  output logic [31:0]              word_cnt,
`endif
  fifo_rd_stream_if.master         bus
);

  logic [OCC_W-1:0] occ;
  logic             pend;
  logic             pop;
  logic             credit_ok;
  logic [WIDTH-1:0] rd_data_c;

  // Words held plus the one in flight must leave room for another read, so
  // the buffer can never overflow regardless of m_ready.
  assign credit_ok = (({1'b0, occ} + (OCC_W + 1)'(pend)) < (OCC_W + 1)'(DEPTH));
  assign bus.rd_en = ~rst & ~bus.empty & credit_ok;

  assign bus.m_valid = (occ != '0);
  assign bus.m_data  = rd_data_c;
  assign pop         = bus.m_valid & bus.m_ready;

  // rd_en delayed by one cycle: marks dout as valid this cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pend <= 1'b0;
    else     pend <= bus.rd_en;
  end

  fifo_rd_buf #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (pend),
    .wr_data   (bus.dout),
    .rd_en     (pop),
    .rd_data_c (rd_data_c),
    .occ       (occ)
  );

`ifdef FIFO_RD_STREAM_CNT_EN
  // Delivered-word counter, wraps modulo 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      word_cnt <= '0;
    else if (pop) word_cnt <= word_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: models ip_fifo as a queue, keeps a scoreboard
// of pushed words, and predicts rd_en/m_valid/m_data from read timestamps.
module tb_fifo_rd_stream;

  localparam int unsigned DEPTH = 3;

  logic clk = 1'b0;
  logic rst;
`ifdef FIFO_RD_STREAM_CNT_EN
  logic [31:0] word_cnt;
`endif

  fifo_rd_stream_if #(.WIDTH(8)) bus ();

  fifo_rd_stream #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
`ifdef FIFO_RD_STREAM_CNT_EN
    .word_cnt (word_cnt),
`endif
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] fq[$];     // contents of the modelled ip_fifo
  logic [7:0] sent[$];   // words pushed and not yet delivered, in order
  int         rq[$];     // cycle numbers of reads not yet delivered
  int         cyc = 0;
  int         pops = 0;
  int         vrun = 0;
  int         vmax = 0;
  int         vcnt = 0;
  bit         rand_ready = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push(input logic [7:0] w);
    fq.push_back(w);
    sent.push_back(w);
    bus.empty = 1'b0;
  endtask

  // One clock cycle: check mid-cycle, then act as ip_fifo at the edge.
  task automatic step();
    bit exp_valid;
    bit took;
    @(negedge clk);
    // A read at cycle r becomes visible to the consumer from cycle r+2.
    exp_valid = (rq.size() > 0) && (rq[0] + 2 <= cyc);
    check("rd_en", 32'(bus.rd_en), 32'(!bus.empty && (rq.size() < DEPTH)));
    check("m_valid", 32'(bus.m_valid), 32'(exp_valid));
    if (exp_valid && sent.size() > 0) check("m_data", 32'(bus.m_data), 32'(sent[0]));
`ifdef FIFO_RD_STREAM_CNT_EN
    check("word_cnt", word_cnt, 32'(pops));
`endif
    if (bus.m_valid) begin
      vrun++;
      vcnt++;
      if (vrun > vmax) vmax = vrun;
    end else begin
      vrun = 0;
    end
    if (exp_valid && bus.m_ready) begin
      void'(rq.pop_front());
      if (sent.size() > 0) void'(sent.pop_front());
      pops++;
    end
    took = bus.rd_en;
    if (took) rq.push_back(cyc);
    @(posedge clk);
    #1;
    if (took && fq.size() > 0) bus.dout = fq.pop_front();
    bus.empty = (fq.size() == 0);
    if (rand_ready) bus.m_ready = 1'($urandom_range(0, 1));
    cyc++;
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while ((sent.size() > 0 || rq.size() > 0) && n < budget) begin
      step();
      n++;
    end
    check(tag, 32'(sent.size() + rq.size()), 32'd0);
  endtask

  initial begin
    int remaining;
    int n;

    // Reset with data apparently available: rd_en must still be held low.
    rst         = 1'b1;
    bus.empty   = 1'b0;
    bus.dout    = 8'h5a;
    bus.m_ready = 1'b1;
    #12;
    check("rst_rd_en", 32'(bus.rd_en), 32'd0);
    check("rst_m_valid", 32'(bus.m_valid), 32'd0);
    bus.empty = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) step();

    // Single word.
    vcnt = 0;
    push(8'h01);
    repeat (6) step();
    check("single_valid_cycles", 32'(vcnt), 32'd1);
    check("single_drain", 32'(sent.size()), 32'd0);

    // Streaming ten words with m_ready held high.
    vmax = 0;
    vrun = 0;
    for (int i = 0; i < 10; i++) fq.push_back(8'(i));
    for (int i = 0; i < 10; i++) sent.push_back(8'(i));
    bus.empty = 1'b0;
    repeat (16) step();
    check("stream_run", 32'(vmax), 32'd10);
    check("stream_drain", 32'(sent.size()), 32'd0);

    // Backpressure: only DEPTH reads may be issued.
    bus.m_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(8'(i));
    repeat (8) step();
    check("bp_reads", 32'(rq.size()), 32'(DEPTH));
    check("bp_fifo_left", 32'(fq.size()), 32'd1);
    bus.m_ready = 1'b1;
    drain("bp_drain", 20);

    // Random arrivals and random backpressure, crossing pointer wrap.
    rand_ready = 1'b1;
    remaining  = 20;
    n = 0;
    while ((remaining > 0 || sent.size() > 0) && n < 400) begin
      if (remaining > 0 && $urandom_range(0, 2) != 0) begin
        push(8'($urandom));
        remaining--;
      end
      step();
      n++;
    end
    check("rand_drain", 32'(sent.size() + remaining), 32'd0);
    rand_ready  = 1'b0;
    bus.m_ready = 1'b1;
    drain("rand_tail", 20);

    // Reset while two words are held and one is in flight.
    bus.m_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(8'(8'h40 + i));
    n = 0;
    while (rq.size() < 3 && n < 20) begin
      step();
      n++;
    end
    check("pre_rst_reads", 32'(rq.size()), 32'd3);
    rst = 1'b1;
    #1;
    check("mid_rst_rd_en", 32'(bus.rd_en), 32'd0);
    check("mid_rst_m_valid", 32'(bus.m_valid), 32'd0);
`ifdef FIFO_RD_STREAM_CNT_EN
    check("mid_rst_word_cnt", word_cnt, 32'd0);
`endif
    fq.delete();
    sent.delete();
    rq.delete();
    pops      = 0;
    bus.empty = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) step();
    bus.m_ready = 1'b1;
    vcnt = 0;
    push(8'ha5);
    repeat (6) step();
    check("post_rst_valid_cycles", 32'(vcnt), 32'd1);
    check("post_rst_drain", 32'(sent.size()), 32'd0);

`ifdef FIFO_RD_STREAM_CNT_EN
    // Six more pops on top of the one above.
    for (int i = 0; i < 6; i++) push(8'(i));
    drain("cnt_drain", 30);
    step();
    check("cnt_seven", word_cnt, 32'd7);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
